// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types, constants and helpers for the frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an asynchronous input followed by
// a rising-edge detector producing a one-clock pulse. STAGES must be >= 2.
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the raw input through the synchronizer and remember the last synchronized value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign pulse = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over back-to-back gate windows of
// GATE_CYCLES clocks and publishes each count through a valid/ready register.
// Optional feature macro: FREQ_METER_RANGE_CHECK_EN adds a registered
// MIN_EDGES..MAX_EDGES window check on in_range; otherwise in_range is 0.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int REF_CLK_HZ  = 50_000_000,
  parameter int GATE_CYCLES = 50_000,
  parameter int CNT_W       = 24,
  parameter int MIN_EDGES   = 990,
  parameter int MAX_EDGES   = 1010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic             saturated,
  output logic             in_range
);

  localparam int               GATE_W    = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Parameter sanity checks, evaluated at elaboration only.
  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("freq_meter: GATE_CYCLES must be at least 2");
  end
  if (MIN_EDGES > MAX_EDGES) begin : g_bad_range
    $error("freq_meter: MIN_EDGES must not exceed MAX_EDGES");
  end
  if (REF_CLK_HZ < 1) begin : g_bad_ref
    $error("freq_meter: REF_CLK_HZ must be positive");
  end

  state_t            state;
  state_t            state_next;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_inc;
  logic              pulse;
  logic              accept;
  logic              clear_cnt;
  logic              load_gate;
  logic              count_en;
  logic              latch_en;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sig_in),
    .pulse(pulse)
  );

  // Edge count including this cycle's pulse, pinned at the counter maximum.
  assign edge_inc = (edge_cnt == CNT_MAX) ? CNT_MAX : edge_cnt + {{(CNT_W-1){1'b0}}, pulse};
  assign accept   = result_valid & result_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: dropping enable mid-window throws the window away.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = ARM;
      ARM:     state_next = MEASURE;
      MEASURE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (gate_cnt == '0) begin
          state_next = LATCH;
        end
      end
      LATCH:   state_next = enable ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    clear_cnt = 1'b0;
    load_gate = 1'b0;
    count_en  = 1'b0;
    latch_en  = 1'b0;
    case (state)
      IDLE:    clear_cnt = 1'b1;
      ARM: begin
        clear_cnt = 1'b1;
        load_gate = 1'b1;
      end
      MEASURE: count_en = 1'b1;
      LATCH:   latch_en = 1'b1;
      default: ;
    endcase
  end

  // Gate down-counter and saturating edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      gate_cnt <= '0;
    end else if (clear_cnt) begin
      edge_cnt <= '0;
      gate_cnt <= load_gate ? GATE_LOAD : '0;
    end else if (count_en) begin
      edge_cnt <= edge_inc;
      if (gate_cnt != '0) begin
        gate_cnt <= gate_cnt - GATE_W'(1);
      end
    end
  end

  // Result register and handshake; a new result overwrites an unaccepted one and flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      saturated    <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (latch_en) begin
      result       <= edge_inc;
      saturated    <= (edge_inc == CNT_MAX);
      result_valid <= 1'b1;
      if (result_valid && !result_ready) begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

`ifdef FREQ_METER_RANGE_CHECK_EN
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_EDGES);

  // Range flag registered with the result; a saturated count is never in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_range <= 1'b0;
    end else if (latch_en) begin
      in_range <= (edge_inc != CNT_MAX) && (edge_inc >= MIN_CNT) && (edge_inc <= MAX_CNT);
    end
  end
`else
  assign in_range = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized self-checking bench for freq_meter. Two instances
// share control inputs: dut_a (CNT_W=8) and dut_b (CNT_W=5, for saturation).
// The reference model predicts each gate window from the enable history and
// counts sig_in rising edges that fall inside it.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G     = 100;
  localparam int WA    = 8;
  localparam int WB    = 5;
  localparam int MIN_E = 9;
  localparam int MAX_E = 11;
  localparam int MAX_A = (1 << WA) - 1;
  localparam int MAX_B = (1 << WB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          result_ready = 1'b0;
  logic          sig_a = 1'b0;
  logic          sig_b = 1'b0;
  logic [WA-1:0] result_a;
  logic          valid_a, overrun_a, sat_a, inr_a;
  logic [WB-1:0] result_b;
  logic          valid_b, overrun_b, sat_b, inr_b;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit rst_h[$];
  bit en_h[$];
  bit rdy_h[$];
  bit sa_h[$];
  bit sb_h[$];

  bit busy;
  int latch_at;
  bit m_valid, m_over;
  int m_res_a, m_res_b;
  bit m_sat_a, m_sat_b, m_inr_a, m_inr_b;

  bit en_c;
  int rdy_mode;
  int per_a, per_b, ph_a, ph_b;

  always #5 clk = ~clk;

  freq_meter #(
    .REF_CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(WA), .MIN_EDGES(MIN_E), .MAX_EDGES(MAX_E)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_a),
    .result(result_a), .result_valid(valid_a), .result_ready(result_ready),
    .overrun(overrun_a), .saturated(sat_a), .in_range(inr_a)
  );

  freq_meter #(
    .REF_CLK_HZ(50_000_000), .GATE_CYCLES(G), .CNT_W(WB), .MIN_EDGES(MIN_E), .MAX_EDGES(MAX_E)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_b),
    .result(result_b), .result_valid(valid_b), .result_ready(result_ready),
    .overrun(overrun_b), .saturated(sat_b), .in_range(inr_b)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // Rising edges of a sig history whose synchronized pulse is sampled at
  // posedges last-G .. last; an edge driven in cycle c is sampled at posedge c+3.
  function automatic int countEdges(input bit h[$], input int last);
    int n;
    n = 0;
    for (int q = last - G; q <= last; q++) begin
      int c;
      c = q - 3;
      if (c >= 1 && c < h.size()) begin
        if (h[c] && !h[c-1]) n++;
      end
    end
    return n;
  endfunction

  function automatic bit rangeOk(input int value, input bit sat);
`ifdef FREQ_METER_RANGE_CHECK_EN
    return !sat && value >= MIN_E && value <= MAX_E;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the window timeline and the handshake model by one posedge.
  task automatic modelStep();
    int  p;
    bit  en, rdy, latch_now;
    int  na, nb;
    p = cyc;
    latch_now = 1'b0;
    if (rst_h[p-1]) begin
      busy = 1'b0; m_valid = 1'b0; m_over = 1'b0;
      m_res_a = 0; m_res_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0; m_inr_a = 1'b0; m_inr_b = 1'b0;
    end else begin
      en  = en_h[p-1];
      rdy = rdy_h[p-1];
      if (!busy) begin
        if (en) begin
          busy = 1'b1;
          latch_at = p + G + 2;
        end
      end else if (p == latch_at) begin
        latch_now = 1'b1;
        if (en) latch_at = p + G + 2;
        else busy = 1'b0;
      end else if (p >= latch_at - G && !en) begin
        busy = 1'b0;
      end
      if (latch_now) begin
        if (m_valid && !rdy) m_over = 1'b1;
        m_valid = 1'b1;
        na = countEdges(sa_h, p);
        nb = countEdges(sb_h, p);
        m_res_a = (na > MAX_A) ? MAX_A : na;
        m_res_b = (nb > MAX_B) ? MAX_B : nb;
        m_sat_a = (m_res_a == MAX_A);
        m_sat_b = (m_res_b == MAX_B);
        m_inr_a = rangeOk(m_res_a, m_sat_a);
        m_inr_b = rangeOk(m_res_b, m_sat_b);
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
        m_over  = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("valid_a", valid_a, m_valid);
    checkOutput("overrun_a", overrun_a, m_over);
    checkOutput("result_a", result_a, m_res_a);
    checkOutput("saturated_a", sat_a, m_sat_a);
    checkOutput("in_range_a", inr_a, m_inr_a);
    checkOutput("valid_b", valid_b, m_valid);
    checkOutput("overrun_b", overrun_b, m_over);
    checkOutput("result_b", result_b, m_res_b);
    checkOutput("saturated_b", sat_b, m_sat_b);
    checkOutput("in_range_b", inr_b, m_inr_b);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_valid_a", valid_a, 0);
    checkOutput("rst_overrun_a", overrun_a, 0);
    checkOutput("rst_result_a", result_a, 0);
    checkOutput("rst_saturated_a", sat_a, 0);
    checkOutput("rst_in_range_a", inr_a, 0);
    checkOutput("rst_valid_b", valid_b, 0);
    checkOutput("rst_result_b", result_b, 0);
    checkOutput("rst_saturated_b", sat_b, 0);
  endtask

  // Drive one cycle of inputs (called at a negedge), then check the next posedge's outputs.
  task automatic applyStimulus(input bit rst_v, input bit en_v, input bit rdy_v, input bit sa_v, input bit sb_v);
    bit fresh_rst;
    fresh_rst = rst_v && !rst;
    if (fresh_rst) #2;
    rst          = rst_v;
    enable       = en_v;
    result_ready = rdy_v;
    sig_a        = rst_v ? 1'b0 : sa_v;
    sig_b        = rst_v ? 1'b0 : sb_v;
    rst_h.push_back(rst_v);
    en_h.push_back(en_v);
    rdy_h.push_back(rdy_v);
    sa_h.push_back(sig_a);
    sb_h.push_back(sig_b);
    if (fresh_rst) begin
      #1;
      checkResetOutputs();
    end
    @(negedge clk);
    cyc++;
    modelStep();
    compareAll();
  endtask

  task automatic genSig(inout int ph, input int per, output bit s);
    if (per <= 0) begin
      s = 1'b0;
    end else begin
      ph = (ph + 1) % per;
      s  = (ph < per / 2);
    end
  endtask

  task automatic runCycles(input int n);
    bit sa, sb, rdy;
    for (int i = 0; i < n; i++) begin
      genSig(ph_a, per_a, sa);
      genSig(ph_b, per_b, sb);
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(1'b0, en_c, rdy, sa, sb);
    end
  endtask

  initial begin
    busy = 1'b0; latch_at = 0; m_valid = 1'b0; m_over = 1'b0;
    m_res_a = 0; m_res_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0; m_inr_a = 1'b0; m_inr_b = 1'b0;
    en_c = 1'b0; rdy_mode = 1; per_a = 0; per_b = 0;
    ph_a = int'($urandom_range(0, 9)); ph_b = int'($urandom_range(0, 9));

    // Power-on reset, then edges while idle must not leak into the first window.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkResetOutputs();
    per_a = 10; per_b = 10;
    runCycles(30);

    // Period 10 with continuous enable and ready.
    en_c = 1'b1; rdy_mode = 1;
    runCycles(5 * (G + 2) + 10);

    // Stuck input yields zero counts.
    per_a = 0; per_b = 0;
    runCycles(3 * (G + 2));

    // Consumer stalls over two windows, then accepts.
    per_a = 10; per_b = 7; rdy_mode = 0;
    runCycles(2 * (G + 2) + 20);
    rdy_mode = 1;
    runCycles(5);

    // Fast input saturates the narrow instance.
    per_a = 3; per_b = 2;
    runCycles(2 * (G + 2) + 5);

    // Enable dropped mid-window, then restarted.
    en_c = 1'b0; runCycles(6);
    per_a = 10; per_b = 4;
    en_c = 1'b1; runCycles(40);
    en_c = 1'b0; runCycles(15);
    en_c = 1'b1; runCycles(2 * (G + 2) + 10);

    // Reset asserted mid-window with an unaccepted result pending.
    en_c = 1'b0; runCycles(6);
    rdy_mode = 0; en_c = 1'b1;
    runCycles(G + 3 + 50);
    repeat (3) applyStimulus(1'b1, en_c, 1'b0, 1'b0, 1'b0);
    rdy_mode = 1;
    runCycles(3 * (G + 2));

    // Randomized mix of periods, ready patterns and enable levels.
    for (int k = 0; k < 12; k++) begin
      per_a    = int'($urandom_range(0, 25));
      per_b    = int'($urandom_range(2, 6));
      rdy_mode = 2;
      en_c     = ($urandom_range(0, 7) != 0);
      runCycles(int'($urandom_range(30, 250)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
